soc_bus_arbiter: RTL and testbench

SOC_BUS_ARBITER -- requirements
Module: soc_bus_arbiter

---
 rtl/soc_bus_arbiter.sv | 162 ++++++++++++++++
 tb/tb_soc_bus_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_bus_arbiter.sv
// soc_bus_arbiter: two-requester round-robin arbiter for one shared downstream
// memory bus. Ownership only changes after a one-cycle GAP (or via IDLE) so the
// downstream controller always sees mem_req drop between owners.
// Optional build macro SOC_ARB_TIMEOUT_EN: aborts a transaction that waits
// TIMEOUT cycles for mem_valid, answering the owner with zero data and an err pulse.
module soc_bus_arbiter #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        res,

    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic        m0_write_en,
    input  logic [3:0]  m0_byte_en,
    input  logic [31:0] m0_write_data,
    output logic [31:0] m0_read_data,
    output logic        m0_valid,

    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic        m1_write_en,
    input  logic [3:0]  m1_byte_en,
    input  logic [31:0] m1_write_data,
    output logic [31:0] m1_read_data,
    output logic        m1_valid,

    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        mem_write_en,
    output logic [3:0]  mem_byte_en,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    input  logic        mem_valid,

    output logic [1:0]  grant,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    // Port served most recently; reset to m1 so the first tie goes to m0.
    logic        last_q, last_d;

    logic        own_req;
    logic        other_req;
    logic [1:0]  pick;
    logic        abort;
    logic [31:0] rdata_fwd;

    // State, owner and round-robin pointer registers.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Request decode: owner/other request and the round-robin choice for the next grant.
    always_comb begin
        own_req   = (grant_q[0] & m0_req) | (grant_q[1] & m1_req);
        other_req = (grant_q[0] & m1_req) | (grant_q[1] & m0_req);
        pick      = '0;
        if (m0_req && m1_req) begin
            pick = last_q ? 2'b01 : 2'b10;
        end else if (m0_req) begin
            pick = 2'b01;
        end else if (m1_req) begin
            pick = 2'b10;
        end
    end

`ifdef SOC_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count stalled owner cycles; completion, abort or leaving BUSY clears the count.
    always_comb begin
        cnt_d = '0;
        if (state_q == BUSY && own_req && !mem_valid && !abort) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign abort = (state_q == BUSY) && own_req && (cnt_q == CNT_W'(TIMEOUT));
`else
    assign abort = 1'b0;
`endif

    // Next-state, next-owner and pointer update.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            IDLE, GAP: begin
                if (pick != 2'b00) begin
                    state_d = BUSY;
                    grant_d = pick;
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            BUSY: begin
                if (abort) begin
                    state_d = GAP;
                    grant_d = '0;
                    last_d  = grant_q[1];
                end else if (!own_req) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else if (mem_valid) begin
                    last_d = grant_q[1];
                    if (other_req) begin
                        state_d = GAP;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Bus steering: only the owner's signals reach mem, only the owner sees responses.
    always_comb begin
        mem_req        = (state_q == BUSY) && own_req && !abort;
        mem_addr       = ({32{grant_q[0]}} & m0_addr)       | ({32{grant_q[1]}} & m1_addr);
        mem_write_en   = (grant_q[0] & m0_write_en)         | (grant_q[1] & m1_write_en);
        mem_byte_en    = ({4{grant_q[0]}} & m0_byte_en)     | ({4{grant_q[1]}} & m1_byte_en);
        mem_write_data = ({32{grant_q[0]}} & m0_write_data) | ({32{grant_q[1]}} & m1_write_data);
        m0_valid       = (state_q == BUSY) && grant_q[0] && (mem_valid || abort);
        m1_valid       = (state_q == BUSY) && grant_q[1] && (mem_valid || abort);
        rdata_fwd      = abort ? '0 : mem_read_data;
    end

    assign m0_read_data = m0_valid ? rdata_fwd : 'z;
    assign m1_read_data = m1_valid ? rdata_fwd : 'z;
    assign grant        = grant_q;
    assign err          = abort;

endmodule

// File: tb/tb_soc_bus_arbiter.sv
// tb_soc_bus_arbiter: cycle table, directed multi-cycle sequences and randomized
// two-port traffic against a behavioural peripheral/memory model.
module tb_soc_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        res;
    logic        m0_req, m0_write_en, m1_req, m1_write_en;
    logic [31:0] m0_addr, m0_write_data, m1_addr, m1_write_data;
    logic [3:0]  m0_byte_en, m1_byte_en;
    wire  [31:0] m0_read_data, m1_read_data;
    logic        m0_valid, m1_valid;
    logic        mem_req, mem_write_en, mem_valid;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;
    logic [3:0]  mem_byte_en;
    logic [1:0]  grant;
    logic        err;

    int checks = 0;
    int errors = 0;
    int served[$];

    // Peripheral model: word memory, programmable response latency.
    logic [31:0] ref_mem [16];
    bit          periph_en = 1'b0;
    bit          rand_lat = 1'b0;
    logic        tbl_valid = 1'b0;
    logic [1:0]  lat_fixed = 2'd1;
    logic [1:0]  lat_rand;
    logic [1:0]  lat;
    int unsigned wcnt;
    int unsigned periph_done;

    assign lat           = rand_lat ? lat_rand : lat_fixed;
    assign mem_valid     = periph_en ? (mem_req && (wcnt >= 32'(lat))) : tbl_valid;
    assign mem_read_data = mem_valid ? ref_mem[mem_addr[5:2]] : 32'hDEAD_BEEF;

    soc_bus_arbiter #(.TIMEOUT(8)) dut (
        .clk(clk), .res(res),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_write_en(m0_write_en),
        .m0_byte_en(m0_byte_en), .m0_write_data(m0_write_data),
        .m0_read_data(m0_read_data), .m0_valid(m0_valid),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_write_en(m1_write_en),
        .m1_byte_en(m1_byte_en), .m1_write_data(m1_write_data),
        .m1_read_data(m1_read_data), .m1_valid(m1_valid),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_write_en(mem_write_en),
        .mem_byte_en(mem_byte_en), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .mem_valid(mem_valid),
        .grant(grant), .err(err)
    );

    // Peripheral: counts wait cycles, applies byte-enabled writes on completion.
    always @(posedge clk or posedge res) begin
        if (res) begin
            for (int i = 0; i < 16; i++) ref_mem[i] <= 32'hC0DE_0000 + 32'(i);
            wcnt        <= 0;
            lat_rand    <= 2'd1;
            periph_done <= 0;
        end else if (periph_en && mem_req) begin
            if (mem_valid) begin
                wcnt        <= 0;
                periph_done <= periph_done + 1;
                lat_rand    <= 2'($urandom_range(0, 3));
                if (mem_write_en) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_byte_en[b])
                            ref_mem[mem_addr[5:2]][8*b +: 8] <= mem_write_data[8*b +: 8];
                end
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wcnt <= 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Continuous rule checker, sampled mid low phase.
    int unsigned wait_comp [2];
    logic [1:0]  prev_grant = 2'b00;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            case (grant)
                2'b00: begin
                    chk("idle_mem_req", mem_req, 0);
                    chk("idle_m0_valid", m0_valid, 0);
                    chk("idle_m1_valid", m1_valid, 0);
                end
                2'b01: begin
                    chk("g0_addr", mem_addr, m0_addr);
                    chk("g0_we", mem_write_en, m0_write_en);
                    chk("g0_be", mem_byte_en, m0_byte_en);
                    chk("g0_wd", mem_write_data, m0_write_data);
                    chk("g0_mem_req", mem_req, m0_req & ~err);
                    chk("g0_other_valid", m1_valid, 0);
                    chk("g0_valid", m0_valid, mem_valid | err);
                    if (m0_valid) chk("g0_rdata", m0_read_data, err ? 32'h0 : mem_read_data);
                end
                2'b10: begin
                    chk("g1_addr", mem_addr, m1_addr);
                    chk("g1_we", mem_write_en, m1_write_en);
                    chk("g1_be", mem_byte_en, m1_byte_en);
                    chk("g1_wd", mem_write_data, m1_write_data);
                    chk("g1_mem_req", mem_req, m1_req & ~err);
                    chk("g1_other_valid", m0_valid, 0);
                    chk("g1_valid", m1_valid, mem_valid | err);
                    if (m1_valid) chk("g1_rdata", m1_read_data, err ? 32'h0 : mem_read_data);
                end
                default: chk("grant_onehot", grant, 2'b00);
            endcase
`ifndef SOC_ARB_TIMEOUT_EN
            chk("err_tied", err, 0);
`endif
            if (prev_grant != 2'b00 && grant != 2'b00) chk("owner_change_no_gap", grant, prev_grant);
            prev_grant = grant;
            for (int p = 0; p < 2; p++) begin
                logic preq, pg, ov;
                preq = (p == 0) ? m0_req : m1_req;
                pg   = grant[p];
                ov   = (p == 0) ? m1_valid : m0_valid;
                if (res || !preq || pg) begin
                    wait_comp[p] = 0;
                end else if (ov) begin
                    wait_comp[p]++;
                    chk(p == 0 ? "fairness_m0" : "fairness_m1", 32'(wait_comp[p] <= 1), 1);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       r0, r1, v;
        logic [1:0] g;
        logic       mreq, v0, v1;
    } vec_t;

    function automatic vec_t mk(input logic r0, r1, v, input logic [1:0] g,
                                input logic mreq, v0, v1);
        vec_t t;
        t.r0 = r0; t.r1 = r1; t.v = v; t.g = g; t.mreq = mreq; t.v0 = v0; t.v1 = v1;
        return t;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        res = 1'b1; m0_req = 1'b0; m1_req = 1'b0; tbl_valid = 1'b0;
        repeat (2) @(negedge clk);
        res = 1'b0;
    endtask

    task automatic txn(input int p, input logic [31:0] a, input logic we,
                       input logic [3:0] be, input logic [31:0] wd, input bit keep);
        bit done = 0;
        if (p == 0) begin
            m0_addr = a; m0_write_en = we; m0_byte_en = be; m0_write_data = wd; m0_req = 1'b1;
        end else begin
            m1_addr = a; m1_write_en = we; m1_byte_en = be; m1_write_data = wd; m1_req = 1'b1;
        end
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            #3;
            if ((p == 0) ? m0_valid : m1_valid) begin
                if (!we) chk("txn_rdata", (p == 0) ? m0_read_data : m1_read_data, ref_mem[a[5:2]]);
                served.push_back(p);
                done = 1;
            end
        end
        if (!done) chk("txn_completion", 0, 1);
        @(posedge clk);
        #1;
        if (!keep) begin
            if (p == 0) m0_req = 1'b0; else m1_req = 1'b0;
        end
    endtask

    vec_t tbl [18];
    int   exp_order [5] = '{0, 1, 0, 1, 0};

    initial begin
        logic [31:0] old_word;
        int unsigned done_before;

        tbl[0]  = mk(0, 0, 0, 2'b00, 0, 0, 0);
        tbl[1]  = mk(1, 1, 0, 2'b00, 0, 0, 0);
        tbl[2]  = mk(1, 1, 0, 2'b01, 1, 0, 0);
        tbl[3]  = mk(1, 1, 1, 2'b01, 1, 1, 0);
        tbl[4]  = mk(1, 1, 0, 2'b00, 0, 0, 0);
        tbl[5]  = mk(1, 1, 1, 2'b10, 1, 0, 1);
        tbl[6]  = mk(0, 1, 1, 2'b00, 0, 0, 0);
        tbl[7]  = mk(0, 1, 1, 2'b10, 1, 0, 1);
        tbl[8]  = mk(0, 1, 0, 2'b10, 1, 0, 0);
        tbl[9]  = mk(0, 0, 0, 2'b10, 0, 0, 0);
        tbl[10] = mk(1, 0, 0, 2'b00, 0, 0, 0);
        tbl[11] = mk(1, 0, 1, 2'b01, 1, 1, 0);
        tbl[12] = mk(1, 1, 0, 2'b01, 1, 0, 0);
        tbl[13] = mk(1, 1, 1, 2'b01, 1, 1, 0);
        tbl[14] = mk(0, 0, 0, 2'b00, 0, 0, 0);
        tbl[15] = mk(0, 0, 0, 2'b00, 0, 0, 0);
        tbl[16] = mk(1, 1, 0, 2'b00, 0, 0, 0);
        tbl[17] = mk(1, 1, 0, 2'b10, 1, 0, 0);

        res = 1'b1;
        m0_req = 0; m0_addr = 32'h10; m0_write_en = 0; m0_byte_en = 4'hF; m0_write_data = 32'h0;
        m1_req = 0; m1_addr = 32'h20; m1_write_en = 0; m1_byte_en = 4'hF; m1_write_data = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_grant", grant, 2'b00);
        chk("reset_mem_req", mem_req, 0);
        chk("reset_err", err, 0);
        res = 1'b0;

        // Cycle table: inputs applied in the low phase, outputs checked before the next edge.
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            m0_req = tbl[i].r0; m1_req = tbl[i].r1; tbl_valid = tbl[i].v;
            #1;
            chk($sformatf("tbl%0d_grant", i), grant, tbl[i].g);
            chk($sformatf("tbl%0d_mem_req", i), mem_req, tbl[i].mreq);
            chk($sformatf("tbl%0d_m0_valid", i), m0_valid, tbl[i].v0);
            chk($sformatf("tbl%0d_m1_valid", i), m1_valid, tbl[i].v1);
        end

        // Asynchronous reset in the middle of a transaction.
        do_reset();
        periph_en = 1'b0;
        @(negedge clk);
        m0_req = 1'b1; m0_addr = 32'h10; m0_write_en = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_pre_grant", grant, 2'b01);
        chk("rst_pre_mem_req", mem_req, 1);
        #2;
        tbl_valid = 1'b1;
        res = 1'b1;
        #1;
        chk("rst_async_grant", grant, 2'b00);
        chk("rst_async_mem_req", mem_req, 0);
        chk("rst_async_m0_valid", m0_valid, 0);
        chk("rst_async_m1_valid", m1_valid, 0);
        m0_req = 1'b0; tbl_valid = 1'b0;
        @(negedge clk);
        res = 1'b0;

        // Single read, peripheral latency 1.
        do_reset();
        periph_en = 1'b1; rand_lat = 1'b0; lat_fixed = 2'd1;
        @(negedge clk);
        m0_req = 1'b1; m0_addr = 32'h10; m0_write_en = 1'b0;
        #1;
        chk("lat1_grant_before_edge", grant, 2'b00);
        @(negedge clk);
        #1;
        chk("lat1_grant", grant, 2'b01);
        chk("lat1_wait_valid", m0_valid, 0);
        @(negedge clk);
        #1;
        chk("lat1_valid", m0_valid, 1);
        chk("lat1_rdata", m0_read_data, 32'hC0DE_0004);
        chk("lat1_m1_valid", m1_valid, 0);
        @(posedge clk);
        #1;
        m0_req = 1'b0;

        // m0 reads a word, m1 then writes the low half of it through a GAP.
        lat_fixed = 2'd2;
        @(negedge clk);
        old_word = ref_mem[15];
        done_before = periph_done;
        fork
            txn(0, 32'h0000_003C, 1'b0, 4'hF, 32'h0, 1'b0);
            begin
                @(posedge clk);
                #1;
                txn(1, 32'h0000_003C, 1'b1, 4'b0011, 32'hA5A5_A5A5, 1'b0);
            end
        join
        @(negedge clk);
        chk("wr_merge", ref_mem[15], {old_word[31:16], 16'hA5A5});
        chk("wr_downstream_count", periph_done - done_before, 2);

        // m0 three back-to-back reads against a continuously requesting m1.
        do_reset();
        lat_fixed = 2'd1;
        served.delete();
        @(negedge clk);
        fork
            begin
                txn(0, 32'h0000_0100, 1'b0, 4'hF, 32'h0, 1'b1);
                txn(0, 32'h0000_0104, 1'b0, 4'hF, 32'h0, 1'b1);
                txn(0, 32'h0000_0108, 1'b0, 4'hF, 32'h0, 1'b0);
            end
            begin
                txn(1, 32'h0000_0204, 1'b0, 4'hF, 32'h0, 1'b1);
                txn(1, 32'h0000_0208, 1'b0, 4'hF, 32'h0, 1'b0);
            end
        join
        chk("rr_count", served.size(), 5);
        for (int i = 0; i < 5 && i < served.size(); i++)
            chk($sformatf("rr_order%0d", i), served[i], exp_order[i]);

        // Randomized traffic on both ports.
        rand_lat = 1'b1;
        fork
            for (int k = 0; k < 30; k++) begin
                bit kp;
                kp = 1'($urandom_range(0, 1));
                txn(0, $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
                    4'($urandom_range(1, 15)), $urandom, kp);
                if (!kp) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            for (int k = 0; k < 30; k++) begin
                bit kp;
                kp = 1'($urandom_range(0, 1));
                txn(1, $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
                    4'($urandom_range(1, 15)), $urandom, kp);
                if (!kp) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
        join
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (3) @(negedge clk);

`ifdef SOC_ARB_TIMEOUT_EN
        // Peripheral never answers: abort after 8 stalled cycles.
        do_reset();
        periph_en = 1'b0; rand_lat = 1'b0;
        @(negedge clk);
        m0_req = 1'b1; m0_addr = 32'h20; m0_write_en = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("to_grant%0d", k), grant, 2'b01);
            if (k < 9) begin
                chk($sformatf("to_stall_valid%0d", k), m0_valid, 0);
                chk($sformatf("to_stall_err%0d", k), err, 0);
                chk($sformatf("to_stall_req%0d", k), mem_req, 1);
            end else begin
                chk("to_abort_valid", m0_valid, 1);
                chk("to_abort_rdata", m0_read_data, 32'h0);
                chk("to_abort_err", err, 1);
                chk("to_abort_no_write", mem_req, 0);
            end
        end
        @(negedge clk);
        #1;
        chk("to_gap_grant", grant, 2'b00);
        chk("to_gap_err", err, 0);
        @(negedge clk);
        #1;
        chk("to_regrant", grant, 2'b01);
        m0_req = 1'b0;
        repeat (2) @(negedge clk);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
